axi4_master_bridge: RTL and testbench
=====================================

// Module: axi4_master_bridge
// PURPOSE
//  Single-outstanding bridge from the simple Red Pitaya system bus (slave side) to an AXI4
//  memory-mapped master port. A sys-bus write or read becomes one single-beat AXI4 burst;
//  the AXI response returns to the requester as ack/rdata/err.
//  Counterpart of the AXI-slave-to-sys-bus bridge: lets PL logic on the simple bus initiate
//  accesses into PS or other AXI slaves.
// PARAMETERS
//  DW       32   data width (8..1024, power of 2); AWSIZE/ARSIZE = log2(DW/8)
//  AW       32   address width
//  IW       8    AXI ID width
//  AXI_ID   0    constant ID driven on AWID/ARID
//  TIMEOUT  32   cycles from request acceptance to forced error ack (>=4)
// PORTS
//  ACLK          in   1      clock; all logic on posedge
//  ARESETn       in   1      asynchronous active-low reset
//  bus_addr      in   AW     sys-bus address, sampled with wen/ren
//  bus_wdata     in   DW     write data, sampled with wen
//  bus_sel       in   DW/8   byte enables, sampled with wen -> WSTRB
//  bus_wen       in   1      one-cycle write request pulse
//  bus_ren       in   1      one-cycle read request pulse
//  bus_rdata     out  DW     read data, valid while bus_ack=1
//  bus_err       out  1      error qualifier, valid while bus_ack=1
//  bus_ack       out  1      one-cycle completion pulse
//  AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out IW/AW/8/3/2  AWID=AXI_ID, AWLEN=0, AWBURST=2'b01
//  AWVALID out 1 / AWREADY in 1      write address handshake
//  WDATA/WSTRB/WLAST out DW/DW/8/1   WLAST=1
//  WVALID out 1 / WREADY in 1        write data handshake
//  BID in IW / BRESP in 2 / BVALID in 1 / BREADY out 1   write response
//  ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out IW/AW/8/3/2  ARID=AXI_ID, ARLEN=0, ARBURST=2'b01
//  ARVALID out 1 / ARREADY in 1      read address handshake
//  RID in IW / RDATA in DW / RRESP in 2 / RLAST in 1 / RVALID in 1 / RREADY out 1
// BEHAVIOUR
//  Reset (async, ARESETn=0): state IDLE; all *VALID, BREADY, RREADY, bus_ack, bus_err = 0;
//   bus_rdata = 0; timeout counter = 0. Reset mid-transaction abandons it; no ack is issued.
//  FSM: IDLE -> WR_REQ -> WR_RESP -> IDLE; IDLE -> RD_REQ -> RD_RESP -> IDLE.
//  IDLE: wen=1 latches addr/wdata/sel and enters WR_REQ. ren=1 (wen=0) latches addr and
//   enters RD_REQ. wen and ren together: write wins, read dropped.
//  Pulses arriving outside IDLE are ignored (requester must wait for ack).
//  WR_REQ: AWVALID and WVALID rise the cycle after wen. Each drops independently on its own
//   handshake (VALID&READY). Both done -> WR_RESP. Payloads stay stable while VALID=1.
//  WR_RESP: BREADY=1. BVALID -> IDLE; bus_ack=1 next cycle; bus_err=BRESP[1].
//  RD_REQ: ARVALID=1 the cycle after ren, held until ARREADY -> RD_RESP.
//  RD_RESP: RREADY=1. RVALID -> IDLE; bus_rdata<=RDATA; bus_ack=1 next cycle;
//   bus_err=RRESP[1] | ~RLAST.
//  Min latency with ready slave: pulse@0, VALID@1, resp VALID@2, bus_ack@3.
//  Timeout: counter clears on request acceptance, increments each non-IDLE cycle. At TIMEOUT
//   it gives one bus_ack with bus_err=1 (bus_rdata=0). The FSM keeps VALIDs per AXI rules and
//   drains the transaction silently; the late response gives no second ack. New requests are
//   ignored until the FSM reaches IDLE.
//  BID/RID not checked (single outstanding). bus_ack never high two consecutive cycles.
// TESTING
//  Write, slave always ready: wen@0 addr=0x40000010 wdata=0xDEADBEEF sel=0xF -> AW/W VALID@1,
//   BRESP=OKAY@2 -> bus_ack@3, err=0, WSTRB=0xF, AWLEN=0, AWSIZE=2.
//  Read with ARREADY delayed 5 cycles, RRESP=OKAY, RDATA=0x12345678 -> ARVALID held stable 5
//   cycles; bus_ack once, rdata=0x12345678, err=0.
//  WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays; single
//   ack after B.
//  Simultaneous wen+ren@0 -> only AW/W issued, no ARVALID, one ack. SLVERR on B -> err=1.
//  Slave never responds (AWREADY=0): bus_ack err=1 exactly TIMEOUT=32 cycles after accept,
//   AWVALID still 1. AWREADY/BVALID later -> no extra ack.
//  ARESETn low while ARVALID=1 -> all VALID/READY/ack 0 immediately (async). After release,
//   ren -> normal read.

Source files
------------

// File: rtl/axi4_master_bridge.sv
// Single-outstanding bridge: simple sys-bus requester -> AXI4 master, one single-beat burst per access.
// A watchdog forces an error ack if the slave stalls; the late AXI response is then drained silently.
module axi4_master_bridge #(
  parameter int          DW      = 32,
  parameter int          AW      = 32,
  parameter int          IW      = 8,
  parameter logic [IW-1:0] AXI_ID = '0,
  parameter int          TIMEOUT = 32
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic [AW-1:0]   bus_addr,
  input  logic [DW-1:0]   bus_wdata,
  input  logic [DW/8-1:0] bus_sel,
  input  logic            bus_wen,
  input  logic            bus_ren,
  output logic [DW-1:0]   bus_rdata,
  output logic            bus_err,
  output logic            bus_ack,
  output logic [IW-1:0]   AWID,
  output logic [AW-1:0]   AWADDR,
  output logic [7:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWVALID,
  input  logic            AWREADY,
  output logic [DW-1:0]   WDATA,
  output logic [DW/8-1:0] WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,
  input  logic [IW-1:0]   BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY,
  output logic [IW-1:0]   ARID,
  output logic [AW-1:0]   ARADDR,
  output logic [7:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [IW-1:0]   RID,
  input  logic [DW-1:0]   RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] SIZE = 3'($clog2(SW));

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   sel_q;
  logic            aw_vld, w_vld, ar_vld;
  logic [CW-1:0]   cnt;
  logic            timed_out;

  logic aw_hs, w_hs, b_hs, r_hs, done;
  logic accept_wr, accept_rd, tmo_fire;

  // IDs are not checked with a single transaction in flight; low RESP bits carry no error info.
  logic unused;
  assign unused = ^{BID, RID, BRESP[0], RRESP[0]};

  assign aw_hs     = aw_vld & AWREADY;
  assign w_hs      = w_vld & WREADY;
  assign b_hs      = (state == WR_RESP) & BVALID;
  assign r_hs      = (state == RD_RESP) & RVALID;
  assign done      = b_hs | r_hs;
  assign accept_wr = (state == IDLE) & bus_wen;
  assign accept_rd = (state == IDLE) & bus_ren & ~bus_wen;
  // bus_ack is registered, so fire one cycle early to land exactly TIMEOUT cycles after acceptance.
  assign tmo_fire  = (state != IDLE) & ~timed_out & ~done & (cnt == CW'(TIMEOUT - 2));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus_wen)      state_nxt = WR_REQ;
        else if (bus_ren) state_nxt = RD_REQ;
      end
      WR_REQ:  if ((~aw_vld | aw_hs) & (~w_vld | w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (BVALID)  state_nxt = IDLE;
      RD_REQ:  if (ARREADY) state_nxt = RD_RESP;
      RD_RESP: if (RVALID)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      aw_vld  <= 1'b0;
      w_vld   <= 1'b0;
      ar_vld  <= 1'b0;
    end else if (accept_wr) begin
      addr_q  <= bus_addr;
      wdata_q <= bus_wdata;
      sel_q   <= bus_sel;
      aw_vld  <= 1'b1;
      w_vld   <= 1'b1;
    end else if (accept_rd) begin
      addr_q  <= bus_addr;
      ar_vld  <= 1'b1;
    end else begin
      if (aw_hs)             aw_vld <= 1'b0;
      if (w_hs)              w_vld  <= 1'b0;
      if (ar_vld && ARREADY) ar_vld <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      if (accept_wr || accept_rd)           cnt <= '0;
      else if (state != IDLE && !timed_out) cnt <= cnt + CW'(1);
      if (done)          timed_out <= 1'b0;
      else if (tmo_fire) timed_out <= 1'b1;
    end
  end

  // A response that arrives after the watchdog fired is consumed without a second ack.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack <= (done & ~timed_out) | tmo_fire;
      bus_err <= 1'b0;
      if (tmo_fire) begin
        bus_err   <= 1'b1;
        bus_rdata <= '0;
      end else if (r_hs && !timed_out) begin
        bus_err   <= RRESP[1] | ~RLAST;
        bus_rdata <= RDATA;
      end else if (b_hs && !timed_out) begin
        bus_err   <= BRESP[1];
      end
    end
  end

  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = SIZE;
  assign AWBURST = 2'b01;
  assign AWVALID = aw_vld;
  assign WDATA   = wdata_q;
  assign WSTRB   = sel_q;
  assign WLAST   = 1'b1;
  assign WVALID  = w_vld;
  assign BREADY  = (state == WR_RESP);
  assign ARID    = AXI_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = SIZE;
  assign ARBURST = 2'b01;
  assign ARVALID = ar_vld;
  assign RREADY  = (state == RD_RESP);

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Directed bench for axi4_master_bridge: the AXI slave is played cycle by cycle from the stimulus.
module tb_axi4_master_bridge;
  localparam int DW = 32, AW = 32, IW = 8;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_sel;
  logic            bus_wen, bus_ren;
  logic [DW-1:0]   bus_rdata;
  logic            bus_err, bus_ack;
  logic [IW-1:0]   AWID, ARID, BID, RID;
  logic [AW-1:0]   AWADDR, ARADDR;
  logic [7:0]      AWLEN, ARLEN;
  logic [2:0]      AWSIZE, ARSIZE;
  logic [1:0]      AWBURST, ARBURST, BRESP, RRESP;
  logic            AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0]   WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;

  int total = 0, bad = 0, acks;

  axi4_master_bridge #(.DW(DW), .AW(AW), .IW(IW), .AXI_ID(8'h00), .TIMEOUT(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .bus_ack(bus_ack),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nx();
    @(posedge ACLK); #1;
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  initial begin
    ARESETn = 1'b0;
    {bus_addr, bus_wdata, bus_sel, bus_wen, bus_ren} = '0;
    {AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID} = '0;
    #23;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_ack", bus_ack, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_readys", {BREADY, RREADY, WVALID}, 0);
    nx(); ARESETn = 1'b1;
    nx();

    // write, slave always ready
    AWREADY = 1; WREADY = 1;
    bus_wen = 1; bus_addr = 32'h4000_0010; bus_wdata = 32'hDEAD_BEEF; bus_sel = 4'hF;
    mid(); chk("w1_c0_awvalid", AWVALID, 0);
    nx(); bus_wen = 0;
    mid();
    chk("w1_awvalid", AWVALID, 1);
    chk("w1_wvalid", WVALID, 1);
    chk("w1_awaddr", AWADDR, 32'h4000_0010);
    chk("w1_wdata", WDATA, 32'hDEAD_BEEF);
    chk("w1_wstrb", WSTRB, 4'hF);
    chk("w1_attr", {AWLEN, AWSIZE, AWBURST, WLAST, AWID}, {8'd0, 3'd2, 2'b01, 1'b1, 8'd0});
    nx(); BVALID = 1; BRESP = 2'b00;
    mid(); chk("w1_bready", {BREADY, AWVALID, WVALID, bus_ack}, 4'b1000);
    nx(); BVALID = 0;
    mid(); chk("w1_ack", {bus_ack, bus_err}, 2'b10);
    nx(); mid(); chk("w1_ack_once", bus_ack, 0);

    // read, ARREADY delayed
    AWREADY = 0; WREADY = 0;
    nx(); bus_ren = 1; bus_addr = 32'h4000_0020;
    for (int i = 1; i <= 5; i++) begin
      nx(); bus_ren = 0; bus_addr = 32'h0; ARREADY = (i == 5);
      mid();
      chk($sformatf("r_arvalid_%0d", i), ARVALID, 1);
      chk($sformatf("r_araddr_%0d", i), ARADDR, 32'h4000_0020);
    end
    nx(); ARREADY = 0; RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b00; RLAST = 1;
    mid(); chk("r_rready", {RREADY, ARVALID, bus_ack}, 3'b100);
    chk("r_arattr", {ARLEN, ARSIZE, ARBURST}, {8'd0, 3'd2, 2'b01});
    nx(); RVALID = 0;
    mid(); chk("r_ack", {bus_ack, bus_err}, 2'b10); chk("r_rdata", bus_rdata, 32'h1234_5678);
    nx(); mid(); chk("r_ack_once", bus_ack, 0);

    // WREADY three cycles ahead of AWREADY
    nx(); bus_wen = 1; bus_addr = 32'h88; bus_wdata = 32'h55; bus_sel = 4'h3;
    nx(); bus_wen = 0; WREADY = 1;
    mid(); chk("o_c1", {AWVALID, WVALID}, 2'b11);
    nx(); WREADY = 0;
    mid(); chk("o_c2", {AWVALID, WVALID}, 2'b10);
    nx(); mid(); chk("o_c3", {AWVALID, WVALID, BREADY}, 3'b100);
    nx(); AWREADY = 1;
    mid(); chk("o_c4", {AWVALID, AWADDR}, {1'b1, 32'h88});
    nx(); AWREADY = 0; BVALID = 1;
    mid(); chk("o_c5", {AWVALID, BREADY, bus_ack}, 3'b010);
    nx(); BVALID = 0;
    mid(); chk("o_ack", {bus_ack, bus_err}, 2'b10);
    nx(); mid(); chk("o_ack_once", bus_ack, 0);

    // wen+ren together, SLVERR on B
    nx(); bus_wen = 1; bus_ren = 1; bus_addr = 32'hC0;
    nx(); bus_wen = 0; bus_ren = 0; AWREADY = 1; WREADY = 1;
    mid(); chk("wr_c1", {AWVALID, WVALID, ARVALID}, 3'b110);
    nx(); AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b10;
    mid(); chk("wr_c2", {ARVALID, BREADY}, 2'b01);
    nx(); BVALID = 0; BRESP = 0;
    mid(); chk("wr_ack_slverr", {bus_ack, bus_err, ARVALID}, 3'b110);
    nx(); mid(); chk("wr_ack_once", {bus_ack, ARVALID, RREADY}, 3'b000);

    // read with RLAST low flags an error
    nx(); bus_ren = 1; bus_addr = 32'h44;
    nx(); bus_ren = 0; ARREADY = 1;
    nx(); ARREADY = 0; RVALID = 1; RDATA = 32'hABCD_0123; RLAST = 0;
    nx(); RVALID = 0; RLAST = 1;
    mid(); chk("nl_ack", {bus_ack, bus_err}, 2'b11); chk("nl_rdata", bus_rdata, 32'hABCD_0123);

    // slave never responds: watchdog ack, then silent drain
    nx(); bus_wen = 1; bus_addr = 32'h99;
    acks = 0;
    for (int k = 1; k <= 39; k++) begin
      nx(); bus_wen = 0; bus_ren = (k == 35);
      mid(); acks += int'(bus_ack);
      if (k == 31) chk("to_early", bus_ack, 0);
      if (k == 32) begin
        chk("to_ack", {bus_ack, bus_err}, 2'b11);
        chk("to_rdata", bus_rdata, 0);
        chk("to_awvalid", AWVALID, 1);
      end
    end
    nx(); bus_ren = 0; AWREADY = 1; WREADY = 1;
    mid(); acks += int'(bus_ack);
    nx(); AWREADY = 0; WREADY = 0; BVALID = 1;
    mid(); acks += int'(bus_ack); chk("to_bready", BREADY, 1);
    nx(); BVALID = 0;
    for (int k = 0; k < 4; k++) begin
      mid(); acks += int'(bus_ack);
      if (k == 1) chk("to_ren_ignored", {ARVALID, AWVALID}, 2'b00);
      nx();
    end
    chk("to_ack_count", acks, 1);

    // async reset while ARVALID is high, then a normal read
    bus_ren = 1; bus_addr = 32'h100;
    nx(); bus_ren = 0;
    mid(); chk("ar_before_rst", ARVALID, 1);
    #2 ARESETn = 0;
    #1 chk("ar_async_rst", {ARVALID, RREADY, BREADY, AWVALID, WVALID, bus_ack}, 6'b0);
    nx(); ARESETn = 1;
    nx(); bus_ren = 1; bus_addr = 32'h200;
    nx(); bus_ren = 0; ARREADY = 1;
    mid(); chk("pr_arvalid", {ARVALID, ARADDR}, {1'b1, 32'h200});
    nx(); ARREADY = 0; RVALID = 1; RDATA = 32'h0BAD_F00D; RLAST = 1;
    mid(); chk("pr_rready", RREADY, 1);
    nx(); RVALID = 0;
    mid(); chk("pr_ack", {bus_ack, bus_err}, 2'b10); chk("pr_rdata", bus_rdata, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
